// File: rtl/uart_tx_fifo_wb_if.sv
// Wishbone bus bundle for the buffered UART transmitter slave.
// Signal names keep the slave-side _i/_o suffixes so they read the same as
// the interconnect netlist they are wired to.
interface uart_tx_fifo_wb_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_stall_o;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        wb_err_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
   );
endinterface

// File: rtl/uart_tx_fifo_wb.sv
// Buffered 8N1 UART transmitter on a Wishbone slave port.
// Software pushes bytes into a small FIFO at offset 0x0; a baud-timed
// serializer drains it LSB first onto tx_o. Offset 0x4 holds status and the
// overflow/irq-enable controls. tx_irq_o flags "everything sent".
module uart_tx_fifo_wb #(
   parameter int SYS_CLK_FREQ = 40000000,
   parameter int BAUD         = 115200,
   parameter int FIFO_AW      = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   uart_tx_fifo_wb_if.slave wb,
   output logic             tx_o,
   output logic             tx_irq_o
);
   localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD;
   localparam int DEPTH        = 2 ** FIFO_AW;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]      BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // bus side
   logic        req, wr_data, wr_ctrl, rd_ctrl;
   logic        ack;
   logic [31:0] rdata;
   logic        overflow, irq_en;
   logic [31:0] status;

   // fifo
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wptr, rptr;
   logic [FIFO_AW:0]   count;
   logic               full, empty, push_ok, pop;

   // serializer
   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   logic unused_bits;
   assign unused_bits = ^{wb.wb_adr_i[31:3], wb.wb_adr_i[1:0],
                          wb.wb_dat_i[31:8], wb.wb_sel_i[3:1]};

   assign req     = wb.wb_cyc_i & wb.wb_stb_i;
   assign wr_data = req &  wb.wb_we_i & ~wb.wb_adr_i[2] & wb.wb_sel_i[0];
   assign wr_ctrl = req &  wb.wb_we_i &  wb.wb_adr_i[2] & wb.wb_sel_i[0];
   assign rd_ctrl = req & ~wb.wb_we_i &  wb.wb_adr_i[2];

   // full is the registered state: a same-cycle pop does not free a slot
   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push_ok = wr_data & ~full;
   assign pop     = (state == S_IDLE) & ~empty;

   assign wb.wb_stall_o = 1'b0;
   assign wb.wb_err_o   = 1'b0;
   assign wb.wb_ack_o   = ack;
   assign wb.wb_dat_o   = rdata;

   // status word assembly
   always_comb begin
      status                 = '0;
      status[0]              = full;
      status[1]              = empty;
      status[2]              = (state != S_IDLE);
      status[3]              = overflow;
      status[4]              = irq_en;
      status[8 +: FIFO_AW+1] = count;
   end

   // single-cycle ack, registered read data, control register writes
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack      <= 1'b0;
         rdata    <= '0;
         overflow <= 1'b0;
         irq_en   <= 1'b0;
      end else begin
         ack   <= req;
         rdata <= rd_ctrl ? status : '0;
         if (wr_data && full)
            overflow <= 1'b1;
         if (wr_ctrl) begin
            if (wb.wb_dat_i[3])
               overflow <= 1'b0;
            irq_en <= wb.wb_dat_i[4];
         end
      end
   end

   // fifo storage, no reset needed since count guards every read
   always_ff @(posedge wb_clk_i) begin
      if (push_ok && !wb_rst_i)
         mem[wptr] <= wb.wb_dat_i[7:0];
   end

   // fifo pointers and occupancy
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // 8N1 serializer; tx_o and tx_irq_o are registered from the current state
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx_o     <= 1'b1;
         tx_irq_o <= 1'b0;
      end else begin
         tx_irq_o <= irq_en & empty & (state == S_IDLE);
         case (state)
            S_START: tx_o <= 1'b0;
            S_DATA:  tx_o <= shift[0];
            default: tx_o <= 1'b1;
         endcase

         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  shift <= mem[rptr];
                  state <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     state   <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo_wb.sv
// Directed bench for uart_tx_fifo_wb with CLKS_PER_BIT = 10.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// A line monitor decodes frames by mid-bit sampling into rx_q / st_q.
module tb_uart_tx_fifo_wb;
   localparam int CPB = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, irq;

   uart_tx_fifo_wb_if bus();

   uart_tx_fifo_wb #(.SYS_CLK_FREQ(100), .BAUD(10), .FIFO_AW(4)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .tx_o     (tx),
      .tx_irq_o (irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;
   int rx_q[$];
   int st_q[$];

   always @(posedge clk) cyc_cnt++;

   // line monitor: start seen low, sample mid-bit; stop==0 flags bit 8
   initial begin
      int st;
      logic [7:0] b;
      forever begin
         @(posedge clk); #2;
         if (tx === 1'b0) begin
            st = cyc_cnt;
            b  = '0;
            for (int i = 0; i < 9; i++) begin
               repeat (i == 0 ? 4 + CPB : CPB) @(posedge clk);
               #2;
               if (i < 8) b[i] = tx;
               else begin
                  rx_q.push_back((tx === 1'b1) ? int'(b) : (int'(b) | 256));
                  st_q.push_back(st);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_bus();
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;
   endtask

   task automatic set_req(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
      bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = sel;
   endtask

   // one request sampled at the next edge; returns ack/data seen after it
   task automatic bus_cycle(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            output logic ack, output logic [31:0] rd);
      set_req(we, adr, dat, sel);
      tick();
      ack = bus.wb_ack_o;
      rd  = bus.wb_dat_o;
      idle_bus();
   endtask

   task automatic test_reset();
      logic a; logic [31:0] d;
      idle_bus();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({tx, irq, bus.wb_ack_o} !== 3'b100) begin
         errors++;
         $display("FAIL reset_outs: got tx/irq/ack=%b expected 100", {tx, irq, bus.wb_ack_o});
      end
      checks++;
      if (bus.wb_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_dat: got %h expected 00000000", bus.wb_dat_o);
      end
      rst = 1'b0;
      bus_cycle(1'b0, 32'h801C, 32'h0, 4'hF, a, d);
      checks++;
      if (a !== 1'b1 || d !== 32'h2) begin
         errors++;
         $display("FAIL reset_status: got ack=%b dat=%h expected ack=1 dat=00000002", a, d);
      end
      tick();
      checks++;
      if (bus.wb_ack_o !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_ack_single: got ack=%b tx=%b expected ack=0 tx=1", bus.wb_ack_o, tx);
      end
   endtask

   task automatic test_frame_a5();
      logic a, a2; logic [31:0] d, d2;
      logic [7:0] bv;
      logic expv;
      int bad, idx;
      bv = 8'hA5;
      bad = 0;
      rx_q.delete(); st_q.delete();
      bus_cycle(1'b1, 32'h8018, 32'hA5, 4'h1, a, d);
      checks++;
      if (a !== 1'b1) begin
         errors++;
         $display("FAIL a5_write_ack: got %b expected 1", a);
      end
      a2 = 1'b0; d2 = '0;
      for (int k = 1; k <= 110; k++) begin
         if (k == 50) set_req(1'b0, 32'h801C, 32'h0, 4'hF);
         tick();
         idx = k - 2;
         if (idx < 0)       expv = 1'b1;
         else if (idx < 10) expv = 1'b0;
         else if (idx < 90) expv = bv[(idx - 10) / 10];
         else               expv = 1'b1;
         if (tx !== expv) bad++;
         if (k == 50) begin
            a2 = bus.wb_ack_o; d2 = bus.wb_dat_o;
            idle_bus();
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL a5_waveform: got %0d wrong tx cycles expected 0", bad);
      end
      checks++;
      if (a2 !== 1'b1 || d2 !== 32'h6) begin
         errors++;
         $display("FAIL a5_status_busy: got ack=%b dat=%h expected ack=1 dat=00000006", a2, d2);
      end
      bus_cycle(1'b0, 32'h801C, 32'h0, 4'hF, a, d);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL a5_status_after: got %h expected 00000002", d);
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] != 32'hA5) begin
         errors++;
         $display("FAIL a5_decoded: got size=%0d first=%h expected size=1 first=a5",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : -1);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] acks;
      logic a, a_after; logic [31:0] d;
      repeat (20) tick();
      rx_q.delete(); st_q.delete();
      set_req(1'b1, 32'h8018, 32'h01, 4'h1);
      tick(); acks[0] = bus.wb_ack_o;
      bus.wb_dat_i = 32'h02;
      tick(); acks[1] = bus.wb_ack_o;
      bus.wb_dat_i = 32'h03;
      tick(); acks[2] = bus.wb_ack_o;
      set_req(1'b0, 32'h801C, 32'h0, 4'hF);
      tick(); a = bus.wb_ack_o; d = bus.wb_dat_o;
      idle_bus();
      tick(); a_after = bus.wb_ack_o;
      checks++;
      if (acks !== 3'b111) begin
         errors++;
         $display("FAIL b2b_acks: got %b expected 111", acks);
      end
      checks++;
      if (a !== 1'b1 || d !== 32'h204) begin
         errors++;
         $display("FAIL b2b_count: got ack=%b dat=%h expected ack=1 dat=00000204", a, d);
      end
      checks++;
      if (a_after !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ack_drop: got %b expected 0", a_after);
      end
      for (int w = 0; w < 500 && rx_q.size() < 3; w++) tick();
      checks++;
      if (rx_q.size() != 3 || rx_q[0] != 1 || rx_q[1] != 2 || rx_q[2] != 3) begin
         errors++;
         $display("FAIL b2b_bytes: got size=%0d expected bytes 01 02 03", rx_q.size());
      end
      checks++;
      if (st_q.size() != 3 || st_q[1] - st_q[0] != 10*CPB + 1 || st_q[2] - st_q[1] != 10*CPB + 1) begin
         errors++;
         $display("FAIL b2b_gap: got spacing %0d,%0d expected %0d",
                  (st_q.size() > 1) ? st_q[1] - st_q[0] : -1,
                  (st_q.size() > 2) ? st_q[2] - st_q[1] : -1, 10*CPB + 1);
      end
   endtask

   task automatic test_overflow();
      logic a; logic [31:0] d;
      int ack_bad, seq_bad;
      repeat (20) tick();
      rx_q.delete(); st_q.delete();
      ack_bad = 0;
      for (int i = 0; i < 18; i++) begin
         set_req(1'b1, 32'h8018, 32'h30 + i, 4'h1);
         tick();
         if (bus.wb_ack_o !== 1'b1) ack_bad++;
      end
      set_req(1'b0, 32'h801C, 32'h0, 4'hF);
      tick(); d = bus.wb_dat_o;
      idle_bus();
      checks++;
      if (ack_bad != 0) begin
         errors++;
         $display("FAIL ovf_acks: got %0d missing acks expected 0", ack_bad);
      end
      checks++;
      if (d !== 32'h100D) begin
         errors++;
         $display("FAIL ovf_status_set: got %h expected 0000100d", d);
      end
      bus_cycle(1'b1, 32'h801C, 32'h08, 4'h1, a, d);
      bus_cycle(1'b0, 32'h801C, 32'h0, 4'hF, a, d);
      checks++;
      if (d !== 32'h1005) begin
         errors++;
         $display("FAIL ovf_status_clr: got %h expected 00001005", d);
      end
      for (int w = 0; w < 2500 && rx_q.size() < 17; w++) tick();
      repeat (150) tick();
      seq_bad = 0;
      for (int i = 0; i < 17; i++)
         if (i >= rx_q.size() || rx_q[i] != 32'h30 + i) seq_bad++;
      checks++;
      if (rx_q.size() != 17 || seq_bad != 0) begin
         errors++;
         $display("FAIL ovf_sequence: got size=%0d wrong=%0d expected size=17 wrong=0",
                  rx_q.size(), seq_bad);
      end
      bus_cycle(1'b0, 32'h801C, 32'h0, 4'hF, a, d);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL ovf_drained: got %h expected 00000002", d);
      end
   endtask

   task automatic test_irq();
      logic a; logic [31:0] d;
      logic expv;
      int bad;
      repeat (20) tick();
      rx_q.delete(); st_q.delete();
      bus_cycle(1'b1, 32'h801C, 32'h10, 4'h1, a, d);
      tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_enable: got %b expected 1", irq);
      end
      bus_cycle(1'b1, 32'h8018, 32'h5A, 4'h1, a, d);
      bad = 0;
      for (int k = 1; k <= 110; k++) begin
         tick();
         expv = (k >= 10*CPB + 2);
         if (irq !== expv) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL irq_frame: got %0d wrong irq cycles expected 0", bad);
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] != 32'h5A) begin
         errors++;
         $display("FAIL irq_byte: got size=%0d expected one byte 5a", rx_q.size());
      end
      bus_cycle(1'b1, 32'h801C, 32'h00, 4'h1, a, d);
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_disable: got %b expected 0", irq);
      end
   endtask

   task automatic test_reset_mid();
      logic a; logic [31:0] d;
      repeat (20) tick();
      set_req(1'b1, 32'h8018, 32'hC3, 4'h1);
      tick();
      bus.wb_dat_i = 32'h11;
      tick();
      bus.wb_dat_i = 32'h22;
      tick();
      idle_bus();
      for (int k = 3; k <= 44; k++) tick();
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_bit3: got tx=%b expected 0", tx);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (tx !== 1'b1 || bus.wb_ack_o !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_tx: got tx=%b ack=%b irq=%b expected 1 0 0", tx, bus.wb_ack_o, irq);
      end
      rst = 1'b0;
      bus_cycle(1'b0, 32'h801C, 32'h0, 4'hF, a, d);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL rstmid_status: got %h expected 00000002", d);
      end
      repeat (150) tick();
      rx_q.delete(); st_q.delete();
      repeat (300) tick();
      checks++;
      if (rx_q.size() != 0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_no_frame: got frames=%0d tx=%b expected 0 frames tx=1", rx_q.size(), tx);
      end
   endtask

   initial begin
      idle_bus();
      test_reset();
      test_frame_a5();
      test_back_to_back();
      test_overflow();
      test_irq();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
